// File: rtl/grid_click_decoder.sv
// -----------------------------------------------------------------------------
// grid_click_decoder
//
// Front end for the tic-tac-toe game FSM. It conditions the raw left mouse
// button and the restart/erase keys with a 2-flop synchronizer and a
// debouncer. On every accepted left press it latches the pointer position and
// maps it onto the 3x3 board. It then emits a fixed-length burst on `cuadro`
// (one-hot cell) and `randomClick` (any press, on or off the board).
//
// Ports
//   clk_100MHz  in   1  single clock
//   reset       in   1  asynchronous active-low reset
//   mouse_x     in  10  pointer column in pixels
//   mouse_y     in  10  pointer row in pixels
//   btn_left    in   1  raw left mouse button (asynchronous)
//   key_restart in   1  raw restart key (asynchronous)
//   key_erase   in   1  raw erase key (asynchronous)
//   cuadro      out  9  one-hot clicked cell, bit = row*3 + col
//   randomClick out  1  any accepted left press
//   restart     out  1  debounced restart level
//   erase       out  1  debounced erase level
// -----------------------------------------------------------------------------

// Two-flop synchronizer followed by a stability-count debouncer.
// The debounced level only follows the synchronized input once the input has
// differed from it for DEB_CYCLES consecutive cycles.
module gcd_sync_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer chain for the asynchronous raw input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count while the input disagrees, flip when it has
  // disagreed long enough, restart the count on any agreement.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

module grid_click_decoder #(
  parameter int unsigned GRID_X0     = 160,
  parameter int unsigned GRID_Y0     = 60,
  parameter int unsigned CELL_W      = 120,
  parameter int unsigned CELL_H      = 120,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       btn_left,
  input  logic       key_restart,
  input  logic       key_erase,
  output logic [8:0] cuadro,
  output logic       randomClick,
  output logic       restart,
  output logic       erase
);

  // Column/row boundaries in 11 bits so the far edge of the board never wraps.
  localparam logic [10:0] X_B0 = 11'(GRID_X0);
  localparam logic [10:0] X_B1 = 11'(GRID_X0 + CELL_W);
  localparam logic [10:0] X_B2 = 11'(GRID_X0 + 2 * CELL_W);
  localparam logic [10:0] X_B3 = 11'(GRID_X0 + 3 * CELL_W);
  localparam logic [10:0] Y_B0 = 11'(GRID_Y0);
  localparam logic [10:0] Y_B1 = 11'(GRID_Y0 + CELL_H);
  localparam logic [10:0] Y_B2 = 11'(GRID_Y0 + 2 * CELL_H);
  localparam logic [10:0] Y_B3 = 11'(GRID_Y0 + 3 * CELL_H);

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_DECODE       = 2'd1,
    S_HOLD         = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_e;

  logic          db_left_s;
  logic          db_restart_s;
  logic          db_erase_s;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [8:0]    cuadro_q, cuadro_d;
  logic          rclick_q, rclick_d;

  logic [10:0]   x_ext_s, y_ext_s;
  logic [2:0]    col_oh_s, row_oh_s;
  logic [8:0]    cell_s;

  gcd_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_left (
    .clk_i  (clk_100MHz),
    .rst_ni (reset),
    .raw_i  (btn_left),
    .db_o   (db_left_s)
  );

  gcd_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_restart (
    .clk_i  (clk_100MHz),
    .rst_ni (reset),
    .raw_i  (key_restart),
    .db_o   (db_restart_s)
  );

  gcd_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_erase (
    .clk_i  (clk_100MHz),
    .rst_ni (reset),
    .raw_i  (key_erase),
    .db_o   (db_erase_s)
  );

  // Map the captured pointer onto the board with constant range compares.
  // A coordinate outside every band leaves its one-hot empty, which in turn
  // clears the whole cell vector.
  always_comb begin
    x_ext_s  = {1'b0, x_q};
    y_ext_s  = {1'b0, y_q};
    col_oh_s = 3'b000;
    row_oh_s = 3'b000;
    cell_s   = 9'b0_0000_0000;
    col_oh_s[0] = (x_ext_s >= X_B0) && (x_ext_s < X_B1);
    col_oh_s[1] = (x_ext_s >= X_B1) && (x_ext_s < X_B2);
    col_oh_s[2] = (x_ext_s >= X_B2) && (x_ext_s < X_B3);
    row_oh_s[0] = (y_ext_s >= Y_B0) && (y_ext_s < Y_B1);
    row_oh_s[1] = (y_ext_s >= Y_B1) && (y_ext_s < Y_B2);
    row_oh_s[2] = (y_ext_s >= Y_B2) && (y_ext_s < Y_B3);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        cell_s[r*3 + c] = row_oh_s[r] & col_oh_s[c];
      end
    end
  end

  // Click FSM next-state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hold_d   = hold_q;
    cuadro_d = cuadro_q;
    rclick_d = rclick_q;
    case (state_q)
      S_IDLE: begin
        cuadro_d = 9'b0_0000_0000;
        rclick_d = 1'b0;
        if (db_left_s) begin
          x_d     = mouse_x;
          y_d     = mouse_y;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        // Outputs are loaded here so they are already valid in the first
        // HOLD cycle.
        cuadro_d = cell_s;
        rclick_d = 1'b1;
        hold_d   = HOLD_MAX;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          cuadro_d = 9'b0_0000_0000;
          rclick_d = 1'b0;
          state_d  = S_WAIT_RELEASE;
        end else begin
          hold_d   = hold_q - HW'(1);
        end
      end
      S_WAIT_RELEASE: begin
        cuadro_d = 9'b0_0000_0000;
        rclick_d = 1'b0;
        if (!db_left_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_RELEASE;
        end
      end
      default: begin
        cuadro_d = 9'b0_0000_0000;
        rclick_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Click FSM state, capture and output registers.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      hold_q   <= '0;
      cuadro_q <= 9'b0_0000_0000;
      rclick_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hold_q   <= hold_d;
      cuadro_q <= cuadro_d;
      rclick_q <= rclick_d;
    end
  end

  assign cuadro      = cuadro_q;
  assign randomClick = rclick_q;
  assign restart     = db_restart_s;
  assign erase       = db_erase_s;

endmodule

// File: tb/tb_grid_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_grid_click_decoder
//
// Directed and randomized bench for grid_click_decoder with a short debounce
// (4 cycles) and a 4-cycle hold. The expected cell comes from plain division
// of the pointer position. The expected timing window comes from the
// end-to-end latency rule: two sync cycles, DEB debounce cycles, then the
// burst starting two cycles after the debounced rise.
// -----------------------------------------------------------------------------
module tb_grid_click_decoder;

  localparam int X0   = 160;
  localparam int Y0   = 60;
  localparam int W    = 120;
  localparam int H    = 120;
  localparam int DEB  = 4;
  localparam int HOLD = 4;
  // Edge count (first edge after the raw change = 1) at which the debounced
  // level changes, and at which the burst starts.
  localparam int DB_LAT    = 2 + DEB;
  localparam int BURST_LAT = DB_LAT + 2;

  logic       clk_100MHz;
  logic       reset;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       btn_left;
  logic       key_restart;
  logic       key_erase;
  logic [8:0] cuadro;
  logic       randomClick;
  logic       restart;
  logic       erase;

  int errors;
  int checks;

  grid_click_decoder #(
    .GRID_X0     (X0),
    .GRID_Y0     (Y0),
    .CELL_W      (W),
    .CELL_H      (H),
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .btn_left    (btn_left),
    .key_restart (key_restart),
    .key_erase   (key_erase),
    .cuadro      (cuadro),
    .randomClick (randomClick),
    .restart     (restart),
    .erase       (erase)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Reference cell: integer division onto the 3x3 board.
  function automatic logic [8:0] ref_cell(input int x, input int y);
    logic [8:0] one;
    int c;
    int r;
    one = 9'd1;
    if (x < X0 || y < Y0) return 9'd0;
    c = (x - X0) / W;
    r = (y - Y0) / H;
    if (c > 2 || r > 2) return 9'd0;
    return one << (r * 3 + c);
  endfunction

  task automatic check_all(input string tag, input logic [8:0] ec, input logic er,
                           input logic erst, input logic eer);
    checks++;
    assert (cuadro === ec) else begin
      errors++;
      $error("FAIL %s cuadro got=%b exp=%b", tag, cuadro, ec);
    end
    checks++;
    assert (randomClick === er) else begin
      errors++;
      $error("FAIL %s randomClick got=%b exp=%b", tag, randomClick, er);
    end
    checks++;
    assert (restart === erst) else begin
      errors++;
      $error("FAIL %s restart got=%b exp=%b", tag, restart, erst);
    end
    checks++;
    assert (erase === eer) else begin
      errors++;
      $error("FAIL %s erase got=%b exp=%b", tag, erase, eer);
    end
  endtask

  // Hold btn_left high for h cycles at (x,y) and check every cycle of a
  // window long enough to cover the burst, release and return to idle.
  // If move is set, the pointer wanders once the position has been captured.
  task automatic run_btn(input int x, input int y, input int h, input bit move);
    logic [8:0] exp_cell;
    bit         burst;
    bit         act;
    int         e;
    exp_cell = ref_cell(x, y);
    burst    = (h >= DEB);
    mouse_x  = 10'(x);
    mouse_y  = 10'(y);
    for (int c = 0; c < h + 24; c++) begin
      @(negedge clk_100MHz);
      btn_left = (c < h);
      if (move && c >= BURST_LAT) begin
        mouse_x = 10'($urandom_range(0, 1023));
        mouse_y = 10'($urandom_range(0, 1023));
      end
      @(posedge clk_100MHz);
      #1;
      e   = c + 1;
      act = burst && (e >= BURST_LAT) && (e <= BURST_LAT + HOLD - 1);
      check_all($sformatf("btn(%0d,%0d,h=%0d) e=%0d", x, y, h, e),
                act ? exp_cell : 9'd0, act, 1'b0, 1'b0);
    end
  endtask

  // Hold one key for h cycles and check both debounced levels each cycle.
  task automatic run_key(input bit is_erase, input int h);
    bit act;
    int e;
    for (int c = 0; c < h + DEB + 10; c++) begin
      @(negedge clk_100MHz);
      if (is_erase) key_erase = (c < h);
      else          key_restart = (c < h);
      @(posedge clk_100MHz);
      #1;
      e   = c + 1;
      act = (h >= DEB) && (e >= DB_LAT) && (e <= DB_LAT + h - 1);
      check_all($sformatf("key(erase=%0d,h=%0d) e=%0d", is_erase, h, e),
                9'd0, 1'b0, is_erase ? 1'b0 : act, is_erase ? act : 1'b0);
    end
  endtask

  initial begin
    int rx;
    int ry;
    int rh;
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    mouse_x     = 10'd0;
    mouse_y     = 10'd0;
    btn_left    = 1'b0;
    key_restart = 1'b0;
    key_erase   = 1'b0;

    // Reset state.
    #2;
    check_all("reset", 9'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);

    // Centre cell, then the board corners and their outside neighbours.
    run_btn(300, 200, 8, 1'b0);
    run_btn(519, 419, 8, 1'b0);
    run_btn(520, 419, 8, 1'b0);
    run_btn(160, 60, 8, 1'b0);
    run_btn(159, 60, 8, 1'b0);
    run_btn(160, 59, 8, 1'b0);
    run_btn(279, 180, 8, 1'b0);
    run_btn(280, 180, 8, 1'b1);

    // Glitch, long hold, then a fresh press.
    run_btn(300, 200, 3, 1'b0);
    run_btn(400, 100, 50, 1'b1);
    run_btn(200, 400, 6, 1'b0);

    // Reset in the middle of a burst.
    mouse_x = 10'd300;
    mouse_y = 10'd200;
    for (int c = 0; c < BURST_LAT + 1; c++) begin
      @(negedge clk_100MHz);
      btn_left = 1'b1;
      @(posedge clk_100MHz);
      #1;
    end
    check_all("pre_reset_hold", 9'b000010000, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all("reset_mid_hold", 9'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_100MHz);
    btn_left = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check_all("in_reset", 9'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    run_btn(450, 350, 7, 1'b0);

    // Keys: normal holds and a glitch.
    run_key(1'b0, 10);
    run_key(1'b1, 10);
    run_key(1'b0, 3);
    run_key(1'b1, 5);

    // Randomized presses, including some glitches and boundary-area points.
    for (int i = 0; i < 12; i++) begin
      rx = $urandom_range(120, 560);
      ry = $urandom_range(20, 460);
      rh = $urandom_range(1, 14);
      run_btn(rx, ry, rh, ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_click_decoder.md
Name: grid_click_decoder

Overview:
Front-end stage that feeds the tic-tac-toe game FSM. It synchronizes and debounces the raw left mouse button and the restart/erase keys. On each accepted press it maps the captured pointer coordinates onto the 3x3 board. It then drives the FSM's inputs: the one-hot cell vector `cuadro`, the any-click strobe `randomClick`, and the debounced `restart`/`erase` levels.

Parameters:
- GRID_X0, 160: left pixel of board column 0.
- GRID_Y0, 60: top pixel of board row 0.
- CELL_W, 120: cell width in pixels.
- CELL_H, 120: cell height in pixels.
- DEB_CYCLES, 1000000: cycles the synchronized input must be stable before the debounced level changes (minimum 2).
- HOLD_CYCLES, 4: cycles `cuadro`/`randomClick` stay asserted per press (minimum 2).

Ports:
- clk_100MHz, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- mouse_x, in, 10: pointer column in pixels.
- mouse_y, in, 10: pointer row in pixels.
- btn_left, in, 1: raw left mouse button, asynchronous.
- key_restart, in, 1: raw restart key, asynchronous.
- key_erase, in, 1: raw erase key, asynchronous.
- cuadro, out, 9: one-hot cell clicked; bit index = row*3 + col.
- randomClick, out, 1: any accepted left press, inside or outside the board.
- restart, out, 1: debounced restart level.
- erase, out, 1: debounced erase level.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, debounce counters and debounced levels clear to 0.
  - FSM goes to IDLE.
  - cuadro=0, randomClick=0, restart=0, erase=0.
  - Reset asserted mid-HOLD clears all outputs immediately.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer, then its own debouncer.
  - Debouncer counter: if sync != db, cnt increments; when cnt reaches DEB_CYCLES-1, db <= sync and cnt <= 0. If sync == db, cnt <= 0.
  - A glitch shorter than DEB_CYCLES never changes db.
- restart = db(key_restart) and erase = db(key_erase), registered levels. No edge logic.
- Coordinate decode:
  - col = 0/1/2 for mouse_x in [X0, X0+W), [X0+W, X0+2W), [X0+2W, X0+3W).
  - row uses the same rule with mouse_y, GRID_Y0 and CELL_H.
  - Any coordinate outside these ranges means "outside".
  - Comparisons are unsigned, 11-bit, so X0+3W cannot overflow.
  - No multipliers or dividers: use constant range compares.
- Control FSM states:
  - IDLE: when db_left=1, capture mouse_x/mouse_y into registers and go to DECODE.
  - DECODE (1 cycle): register the cell one-hot vector (0 if outside). Load hold_cnt = HOLD_CYCLES-1. Go to HOLD.
  - HOLD: cuadro = captured one-hot and randomClick = 1, every cycle. Decrement hold_cnt; at 0, go to WAIT_RELEASE.
  - WAIT_RELEASE: outputs 0. Go to IDLE when db_left=0.
- Timing and press rules:
  - If db_left rises in cycle T, outputs are high in cycles T+2 through T+1+HOLD_CYCLES.
  - A press yields exactly one burst.
  - Holding the button never retriggers.
  - A new press is accepted only after release is observed in WAIT_RELEASE.
  - Pointer motion after capture does not alter the burst.
- At most one cuadro bit is ever set.
- Pixel boundaries are inclusive on the low edge and exclusive on the high edge.

Test Plan:
1. DEB_CYCLES=4: press btn_left at (300,200) -> cuadro=9'b000010000 and randomClick=1 for exactly 4 cycles, starting 2 cycles after db_left rises; then 0.
2. Press at (519,419) -> cuadro=9'b100000000. Press at (520,419) -> cuadro=0, randomClick=1 for 4 cycles.
3. Press at (160,60) -> cuadro=9'b000000001. Press at (159,60) -> cuadro=0, randomClick=1.
4. 3-cycle btn_left glitch -> no output. Button held 50 cycles -> a single 4-cycle burst. Release, then press again -> a second burst.
5. Drive reset=0 during HOLD -> cuadro and randomClick are 0 in the same cycle. After release, the next press decodes normally.
6. key_restart held 10 cycles -> restart=1 from about 6 cycles after the edge (2 sync + 4 debounce) and follows the release with the same delay. key_erase behaves identically and independently.
